// File: rtl/regfile_writeback.sv
// Write-side front end for the register file: mem/alu arbitration into an in-order
// write queue that drains one entry per cycle. Define REGFILE_WB_BYPASS_EN for bypass lookup.
`timescale 1ns/1ps

module regfile_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     wr_stall,
    output logic [ADDR_W-1:0]        write_addr,
    output logic [DATA_W-1:0]        write_data,
    output logic                     write_enable,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Readies come from the pre-edge count only, so a same-cycle pop never frees a slot early.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_addr = mem_valid ? mem_addr : alu_addr;
    assign push_data = mem_valid ? mem_data : alu_data;

    assign write_enable = !empty && !wr_stall;
    assign pop          = write_enable;
    assign write_addr   = empty ? '0 : addr_mem[rd_ptr];
    assign write_data   = empty ? '0 : data_mem[rd_ptr];
    assign level        = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage is deliberately not reset; count masks every read, so stale contents stay invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // NOTE: every output of this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        // Scan oldest to youngest; a later match overrides, leaving the youngest value.
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (addr_mem[rd_ptr + PTR_W'(i)] == rd_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem[rd_ptr + PTR_W'(i)];
                end
                if (addr_mem[rd_ptr + PTR_W'(i)] == rd_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem[rd_ptr + PTR_W'(i)];
                end
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr1, rd_addr2};
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule
